// File: rtl/rv32im_mul_if.sv
// Handshake and operand bundle between the execute stage and the iterative multiplier.
// Signal suffixes are relative to the multiplier (slave) side.
`timescale 1ns/1ps
interface rv32im_mul_if #(
    parameter int WIDTH = 32
);
    logic             clear_i;
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output clear_i, start_i, op_i, a_i, b_i,
        input  busy_o, valid_o, result_o
    );

    modport slave (
        input  clear_i, start_i, op_i, a_i, b_i,
        output busy_o, valid_o, result_o
    );
endinterface

// File: rtl/rv32im_mul.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Multiplies operand magnitudes over WIDTH cycles, then sign-corrects and picks the word.
`timescale 1ns/1ps
module rv32im_mul #(
    parameter int WIDTH = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    rv32im_mul_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   aMag_q, aMag_d;
    logic [WIDTH-1:0]   bMag_q, bMag_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               neg_q, neg_d;
    logic               hiSel_q, hiSel_d;
    logic               valid_q, valid_d;

    logic               aNeg, bNeg;
    logic [WIDTH-1:0]   aAbs, bAbs;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] fixed;

    // Only MULH/MULHSU treat rs1 as signed and only MULH treats rs2 as signed.
    always_comb begin
        aNeg  = ((bus.op_i == 2'b01) || (bus.op_i == 2'b10)) && bus.a_i[WIDTH-1];
        bNeg  = (bus.op_i == 2'b01) && bus.b_i[WIDTH-1];
        aAbs  = aNeg ? (~bus.a_i + WIDTH'(1)) : bus.a_i;
        bAbs  = bNeg ? (~bus.b_i + WIDTH'(1)) : bus.b_i;
        sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (bMag_q[0] ? {1'b0, aMag_q} : '0);
        fixed = neg_q ? (~prod_q + (2*WIDTH)'(1)) : prod_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        aMag_d   = aMag_q;
        bMag_d   = bMag_q;
        prod_d   = prod_q;
        result_d = result_q;
        neg_d    = neg_q;
        hiSel_d  = hiSel_q;
        valid_d  = valid_q;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = RUN;
                    aMag_d  = aAbs;
                    bMag_d  = bAbs;
                    neg_d   = aNeg ^ bNeg;
                    hiSel_d = (bus.op_i != 2'b00);
                    prod_d  = '0;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end
            end
            RUN: begin
                // The carry out of the add becomes the new MSB after the right shift.
                prod_d = {sum, prod_q[WIDTH-1:1]};
                bMag_d = bMag_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                prod_d   = fixed;
                result_d = hiSel_q ? fixed[2*WIDTH-1:WIDTH] : fixed[WIDTH-1:0];
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bus.clear_i) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            aMag_q   <= '0;
            bMag_q   <= '0;
            prod_q   <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            hiSel_q  <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            aMag_q   <= aMag_d;
            bMag_q   <= bMag_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            hiSel_q  <= hiSel_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.busy_o   = (state_q != IDLE);
    assign bus.valid_o  = valid_q;
    assign bus.result_o = result_q;
endmodule
